// File: rtl/mu0_pkg.sv
// rtl/mu0_pkg.sv - MU0 opcode constants, sequencer state type and opcode class helpers
package mu0_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_STA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_JMP = 4'b0100;
  localparam logic [3:0] OP_JMI = 4'b0101;
  localparam logic [3:0] OP_JEQ = 4'b0110;
  localparam logic [3:0] OP_STP = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1000;
  localparam logic [3:0] OP_LSL = 4'b1001;
  localparam logic [3:0] OP_LSR = 4'b1010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_HALT
  } seq_state_t;

  // Opcodes needing a second execute phase (memory operand read).
  function automatic logic is_extra(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Everything above LSR is undefined.
  function automatic logic is_illegal(input logic [3:0] op);
    return op > OP_LSR;
  endfunction

endpackage

// File: rtl/mu0_sequencer_if.sv
// rtl/mu0_sequencer_if.sv - control/status bundle between MU0 sequencer and its controller
interface mu0_sequencer_if #(
  parameter int CNT_W = 16
) ();
  logic             run;
  logic             step;
  logic [3:0]       op;
  logic             mem_ready;
  logic             fetch;
  logic             exec1;
  logic             exec2;
  logic             halted;
  logic             illegal;
  logic             busy;
  logic [CNT_W-1:0] instr_count;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output run, step, op, mem_ready,
    input  fetch, exec1, exec2, halted, illegal, busy, instr_count, cycle_count
  );

  modport slave (
    input  run, step, op, mem_ready,
    output fetch, exec1, exec2, halted, illegal, busy, instr_count, cycle_count
  );
endinterface

// File: rtl/mu0_wrap_counter.sv
// rtl/mu0_wrap_counter.sv - free-wrapping counter with synchronous clear and enable
module mu0_wrap_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mu0_sequencer.sv
// rtl/mu0_sequencer.sv - MU0 fetch/exec phase sequencer with run/step control and debug counters
module mu0_sequencer
  import mu0_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  mu0_sequencer_if.slave bus
);

  seq_state_t state, state_next;
  logic       step_mode, step_mode_next;
  logic       illegal_q, illegal_next;
  logic       instr_done;
  seq_state_t boundary_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      step_mode <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_next;
      step_mode <= step_mode_next;
      illegal_q <= illegal_next;
    end
  end

  // A stepped instruction only chains into the next one if run was raised meanwhile.
  assign boundary_state = (bus.run && !step_mode) ? S_FETCH : S_IDLE;

  always_comb begin
    state_next     = state;
    step_mode_next = bus.run ? 1'b0 : step_mode;
    illegal_next   = illegal_q;
    instr_done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.run || bus.step) begin
          state_next     = S_FETCH;
          step_mode_next = ~bus.run;
        end
      end
      S_FETCH: begin
        if (bus.mem_ready) state_next = S_EXEC1;
      end
      S_EXEC1: begin
        if (bus.mem_ready) begin
          if (is_illegal(bus.op)) begin
            state_next   = S_HALT;
            illegal_next = 1'b1;
            instr_done   = 1'b1;
          end else if (bus.op == OP_STP) begin
            state_next = S_HALT;
            instr_done = 1'b1;
          end else if (is_extra(bus.op)) begin
            state_next = S_EXEC2;
          end else begin
            state_next = boundary_state;
            instr_done = 1'b1;
          end
        end
      end
      S_EXEC2: begin
        if (bus.mem_ready) begin
          state_next = boundary_state;
          instr_done = 1'b1;
        end
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.fetch   = (state == S_FETCH);
  assign bus.exec1   = (state == S_EXEC1);
  assign bus.exec2   = (state == S_EXEC2);
  assign bus.halted  = (state == S_HALT);
  assign bus.busy    = (state == S_FETCH) || (state == S_EXEC1) || (state == S_EXEC2);
  assign bus.illegal = illegal_q;

  mu0_wrap_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .clear (reset),
    .en    (instr_done),
    .count (bus.instr_count)
  );

  mu0_wrap_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .clear (reset),
    .en    (bus.busy),
    .count (bus.cycle_count)
  );

endmodule

// File: tb/tb_mu0_sequencer.sv
// tb/tb_mu0_sequencer.sv - self-checking bench for mu0_sequencer: directed scenarios plus random run against a behavioural model
module tb_mu0_sequencer;
  import mu0_pkg::*;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mu0_sequencer_if #(.CNT_W(W)) bus ();
  mu0_sequencer #(.CNT_W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chks(input string name, input string act, input string exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  // Behavioural model: where are we inside the current instruction, and what has been counted.
  int m_phase;  // 0 = not in an instruction, 1 = fetch, 2 = first execute, 3 = second execute
  bit m_halt, m_ill, m_stepping, m_done;
  int m_ic, m_cc;
  bit check_en = 1'b0;

  // Number of execute phases an opcode needs; 0 = stop, -1 = undefined.
  function automatic int exec_phases(input logic [3:0] o);
    case (o)
      4'd0, 4'd2, 4'd3:                        return 2;
      4'd1, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10: return 1;
      4'd7:                                    return 0;
      default:                                 return -1;
    endcase
  endfunction

  always @(posedge clk) begin
    m_done = 1'b0;
    if (reset) begin
      m_phase = 0; m_halt = 0; m_ill = 0; m_stepping = 0; m_ic = 0; m_cc = 0;
    end else if (!m_halt) begin
      if (m_phase != 0) m_cc = (m_cc + 1) % MOD;
      if (m_phase == 0) begin
        if (bus.run || bus.step) begin
          m_phase    = 1;
          m_stepping = !bus.run;
        end
      end else if (bus.mem_ready) begin
        if (m_phase == 1) begin
          m_phase = 2;
        end else if (m_phase == 2 && exec_phases(bus.op) <= 0) begin
          m_halt  = 1;
          m_ill   = exec_phases(bus.op) < 0;
          m_phase = 0;
          m_ic    = (m_ic + 1) % MOD;
        end else if (m_phase == 2 && exec_phases(bus.op) == 2) begin
          m_phase = 3;
        end else begin
          m_done = 1'b1;
        end
      end
      if (m_done) begin
        m_ic    = (m_ic + 1) % MOD;
        m_phase = (bus.run && !m_stepping) ? 1 : 0;
      end
      if (bus.run) m_stepping = 0;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("fetch",       int'(bus.fetch),       int'(m_phase == 1));
      chk("exec1",       int'(bus.exec1),       int'(m_phase == 2));
      chk("exec2",       int'(bus.exec2),       int'(m_phase == 3));
      chk("busy",        int'(bus.busy),        int'(m_phase != 0));
      chk("halted",      int'(bus.halted),      int'(m_halt));
      chk("illegal",     int'(bus.illegal),     int'(m_ill));
      chk("instr_count", int'(bus.instr_count), m_ic);
      chk("cycle_count", int'(bus.cycle_count), m_cc);
    end
  end

  string trace;
  bit    rec = 1'b0;
  always @(negedge clk) begin
    if (rec) begin
      if (bus.fetch)      trace = {trace, "F"};
      else if (bus.exec1) trace = {trace, "1"};
      else if (bus.exec2) trace = {trace, "2"};
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    check_en = 1'b1;
  endtask

  // sel: 1 exec1, 2 exec2, 3 not busy, 4 halted
  task automatic wait_for(input string name, input int sel);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      case (sel)
        1:       hit = bus.exec1;
        2:       hit = bus.exec2;
        3:       hit = !bus.busy;
        default: hit = bus.halted;
      endcase
    end
    if (!hit) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic feed(input logic [3:0] o);
    wait_for("feed", 1);
    bus.op = o;
  endtask

  task automatic step_pulse();
    bus.step = 1'b1;
    cyc(1);
    bus.step = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.run = 1'b0; bus.step = 1'b0; bus.op = OP_JMP; bus.mem_ready = 1'b1;
    cyc(2);

    // Free-run program LDA, STA, ADD, STP.
    do_reset();
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_ic", int'(bus.instr_count), 0);
    trace = ""; rec = 1'b1;
    bus.run = 1'b1;
    feed(OP_LDA); feed(OP_STA); feed(OP_ADD); feed(OP_STP);
    wait_for("t1_halt", 4);
    rec = 1'b0;
    chks("t1_trace", trace, "F12F1F12F1");
    chk("t1_halted", int'(bus.halted), 1);
    chk("t1_ic", int'(bus.instr_count), 4);
    chk("t1_cc", int'(bus.cycle_count), 10);
    chk("t1_illegal", int'(bus.illegal), 0);

    // Single step JMP twice.
    bus.run = 1'b0;
    do_reset();
    bus.op = OP_JMP;
    trace = ""; rec = 1'b1;
    step_pulse();
    wait_for("t2_idle", 3);
    cyc(3);
    chks("t2_trace1", trace, "F1");
    chk("t2_ic1", int'(bus.instr_count), 1);
    trace = "";
    step_pulse();
    wait_for("t2_idle2", 3);
    cyc(3);
    rec = 1'b0;
    chks("t2_trace2", trace, "F1");
    chk("t2_ic2", int'(bus.instr_count), 2);
    chk("t2_cc2", int'(bus.cycle_count), 4);

    // SUB stalled three cycles in EXEC2.
    do_reset();
    bus.op = OP_SUB;
    trace = ""; rec = 1'b1;
    step_pulse();
    wait_for("t3_e2", 2);
    bus.mem_ready = 1'b0;
    cyc(3);
    bus.mem_ready = 1'b1;
    wait_for("t3_idle", 3);
    rec = 1'b0;
    chks("t3_trace", trace, "F12222");
    chk("t3_cc", int'(bus.cycle_count), 6);
    chk("t3_ic", int'(bus.instr_count), 1);

    // Illegal opcode halts; run/step ignored; reset clears.
    do_reset();
    bus.op = 4'b1100;
    bus.run = 1'b1;
    wait_for("t4_halt", 4);
    chk("t4_illegal", int'(bus.illegal), 1);
    for (int i = 0; i < 4; i++) begin
      bus.run  = ~bus.run;
      bus.step = ~bus.step;
      cyc(1);
    end
    chk("t4_still_halted", int'(bus.halted), 1);
    chk("t4_ic", int'(bus.instr_count), 1);
    chk("t4_cc", int'(bus.cycle_count), 2);
    bus.run = 1'b0; bus.step = 1'b0;
    do_reset();
    chk("t4_rst_halted", int'(bus.halted), 0);
    chk("t4_rst_illegal", int'(bus.illegal), 0);

    // Reset mid-EXEC2, then drop run during EXEC1 of ADD.
    bus.op = OP_ADD;
    bus.run = 1'b1;
    wait_for("t5_e2", 2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("t5_busy", int'(bus.busy), 0);
    chk("t5_cc", int'(bus.cycle_count), 0);
    trace = ""; rec = 1'b1;
    wait_for("t5_e1", 1);
    bus.run = 1'b0;
    wait_for("t5_idle", 3);
    cyc(3);
    rec = 1'b0;
    chks("t5_trace", trace, "F12");
    chk("t5_ic", int'(bus.instr_count), 1);

    // Counter wrap with 4-bit counters.
    do_reset();
    bus.op = OP_JMP;
    bus.run = 1'b1;
    cyc(31);
    chk("t6_ic15", int'(bus.instr_count), 15);
    chk("t6_cc30", int'(bus.cycle_count), 14);
    cyc(2);
    chk("t6_ic_wrap", int'(bus.instr_count), 0);
    chk("t6_cc_wrap", int'(bus.cycle_count), 0);
    chk("t6_fetch", int'(bus.fetch), 1);
    bus.run = 1'b0;
    wait_for("t6_idle", 3);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 2) bus.run = $urandom_range(0, 1);
      bus.step      = ($urandom_range(0, 7) == 0);
      bus.op        = 4'($urandom_range(0, 15));
      bus.mem_ready = ($urandom_range(0, 4) != 0);
      reset         = ($urandom_range(0, 59) == 0);
      cyc(1);
    end
    reset = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mu0_sequencer.md
# mu0_sequencer

Control-state sequencer for the MU0 core: generates the one-hot `fetch` / `exec1` / `exec2` phase strobes that the instruction decoder consumes. It walks each instruction through its phases from the current opcode, stretches phases while memory is not ready, and halts on STP or an illegal opcode. It supports free-run and single-step operation, and keeps instruction and cycle counters for debug.

## Interface
- `CNT_W`, default 16: width of `instr_count` and `cycle_count`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: level; 1 = free-run, 0 = stop at the next instruction boundary.
- `step` in 1: single-cycle pulse; from IDLE, executes exactly one instruction.
- `op` in 4: opcode from IR; valid and used only during EXEC1.
- `mem_ready` in 1: RAM handshake; a phase completes only on a cycle where this is 1.
- `fetch` out 1: FETCH phase strobe.
- `exec1` out 1: EXEC1 phase strobe.
- `exec2` out 1: EXEC2 phase strobe.
- `halted` out 1: sequencer is in HALT.
- `illegal` out 1: sticky; HALT was caused by an undefined opcode.
- `busy` out 1: state is FETCH, EXEC1 or EXEC2.
- `instr_count` out CNT_W: number of completed instructions.
- `cycle_count` out CNT_W: number of cycles with `busy` = 1.

## Operation
- States: IDLE, FETCH, EXEC1, EXEC2, HALT.
- Outputs are registered from state: `fetch`=FETCH, `exec1`=EXEC1, `exec2`=EXEC2. At most one strobe is high in any cycle.
- Opcode classes (from op):
  - Extra: LDA 0000, ADD 0010, SUB 0011.
  - Single-phase: STA 0001, JMP 0100, JMI 0101, JEQ 0110, LDI 1000, LSL 1001, LSR 1010.
  - Stop: STP 0111.
  - Illegal: 1011–1111.
- Transitions (a phase completes only when `mem_ready`=1; otherwise the state holds):
  - IDLE → FETCH when `run`=1 or `step`=1. Step mode is latched into an internal `step_mode` flag, set to `~run`.
  - FETCH → EXEC1.
  - EXEC1, Extra opcode → EXEC2.
  - EXEC1, single-phase opcode → end of instruction.
  - EXEC1, STP → HALT; `illegal`=0.
  - EXEC1, illegal opcode → HALT; `illegal`=1.
  - EXEC2 → end of instruction.
- End of instruction:
  - `instr_count` += 1.
  - Next state is FETCH if `run`=1 and `step_mode`=0; otherwise IDLE.
- STP and illegal opcodes also increment `instr_count`.
- HALT exits only via `reset`; `run` and `step` are ignored in HALT.
- `step` is ignored outside IDLE. If `run` rises during a stepped instruction, the machine continues in free-run from the next boundary: `step_mode` is cleared while `run`=1.
- `run` falling mid-instruction: the current instruction completes, then the machine goes to IDLE. It never stops mid-instruction.
- `cycle_count` += 1 every cycle with `busy`=1, including `mem_ready` wait cycles.
- Both counters wrap modulo 2^CNT_W with no saturation.

## Timing
- Reset (sync, active-high) forces: state=IDLE, `fetch`/`exec1`/`exec2`=0, `halted`=0, `illegal`=0, `busy`=0, `step_mode`=0, both counters 0. This takes effect on the next edge from any state, including mid-instruction and wait-stalled cycles.
- `reset` has priority over `run` and `step` in the same cycle.
- Latency from `run` asserted in IDLE to `fetch`=1: 1 cycle.
- With `mem_ready`=1 throughout:
  - Single-phase instruction: 2 cycles.
  - Extra instruction: 3 cycles.
  - Back-to-back instructions have no bubble.
- Each cycle with `mem_ready`=0 adds one cycle to the current phase. Strobes stay high across the stall.
- `op` is sampled combinationally in the last (ready) cycle of EXEC1 only.
- `halted` rises in the cycle after the completing EXEC1 of STP or an illegal opcode.

## Structure
- Shared package `mu0_pkg`:
  - 4-bit opcode constants (LDA … LSR, STP).
  - State enum `seq_state_t`.
  - `is_extra(op)` and `is_illegal(op)` functions, shared with the decoder.
- Sub-module `mu0_wrap_counter`: parameterized CNT_W, sync clear, enable. Instantiated twice (instruction and cycle counts).
- FSM and step/run logic live in `mu0_sequencer` itself.

## Test plan
- Reset, then `run`=1, op stream LDA, STA, ADD, STP, `mem_ready`=1 → strobe sequence F,E1,E2, F,E1, F,E1,E2, F,E1; then `halted`=1, `instr_count`=4, `cycle_count`=10.
- `run`=0, `step` pulsed once, op=JMP → F,E1, then IDLE; `instr_count`=1. A second `step` pulse runs exactly one more instruction.
- op=SUB with `mem_ready` low for 3 cycles in EXEC2 → `exec2` held for 4 cycles; `cycle_count`=6 for that instruction.
- op=1100 in EXEC1 → HALT with `illegal`=1; `run`/`step` toggled in HALT → no change; `reset` → IDLE with all outputs 0.
- `reset` asserted during EXEC2 → next cycle IDLE, counters 0; drop `run` during E1 of an ADD → E2 completes, then IDLE.
- CNT_W=4, 16 single-phase instructions in free-run → `instr_count` wraps to 0; `cycle_count` wraps to 0 after 16 busy cycles.
